// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM pin interface.
// State encoding and default pin widths used by controller and responder.
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WRITE      = 2'd1;
  localparam logic [1:0] ST_READ_WAIT  = 2'd2;
  localparam logic [1:0] ST_READ_DRIVE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE       = ST_IDLE,
    S_WRITE      = ST_WRITE,
    S_READ_WAIT  = ST_READ_WAIT,
    S_READ_DRIVE = ST_READ_DRIVE
  } sram_state_e;

endpackage

// File: rtl/sram_resp_array.sv
// Word array behind the SRAM responder.
// One synchronous write port and one registered read port.
module sram_resp_array #(
  parameter int DEPTH_W = 8,
  parameter int DATA_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [DEPTH_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]  i_wdata,
  input  logic [DEPTH_W-1:0] i_raddr,
  output logic [DATA_W-1:0]  o_rdata
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_responder.sv
// Responder end of the asynchronous SRAM pin interface.
// Samples strobes on CLK, commits on WE rise, drives reads after a latency.
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int DEPTH_W  = 8,
  parameter int READ_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              OE,
  input  logic              WE,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  output logic              conflict,
  output logic [15:0]       write_count
);

  localparam logic [3:0] LAT = 4'(READ_LAT);

  logic              r_s_en;
  logic              r_s_oe;
  logic              r_s_we;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_data;

  sram_state_e        r_state;
  logic [3:0]         r_cnt;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [DEPTH_W-1:0] r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic               r_drive;
  logic               r_conflict;
  logic [15:0]        r_write_count;

  logic              w_rd_ok;
  logic              w_commit;
  logic              w_addr_chg;
  logic [3:0]        w_cnt_inc;
  logic [DATA_W-1:0] w_rdata;

  assign w_rd_ok    = !r_s_en && !r_s_oe && r_s_we;
  assign w_commit   = (r_state == S_WRITE) && r_s_we && !RST;
  assign w_addr_chg = (r_s_addr != r_rd_addr);
  assign w_cnt_inc  = 4'(r_cnt + 4'd1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s_en        <= 1'b1;
      r_s_oe        <= 1'b1;
      r_s_we        <= 1'b1;
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_drive       <= 1'b0;
      r_conflict    <= 1'b0;
      r_write_count <= 16'd0;
    end else begin
      r_s_en   <= EN;
      r_s_oe   <= OE;
      r_s_we   <= WE;
      r_s_addr <= address;
      r_s_data <= data;
      if (!r_s_en && !r_s_we && !r_s_oe) begin
        r_conflict <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (!r_s_en && !r_s_we) begin
            r_state   <= S_WRITE;
            r_wr_addr <= r_s_addr[DEPTH_W-1:0];
            r_wr_data <= r_s_data;
          end else if (w_rd_ok) begin
            r_rd_addr <= r_s_addr;
            r_cnt     <= 4'd1;
            if (LAT <= 4'd1) begin
              r_state <= S_READ_DRIVE;
              r_drive <= 1'b1;
            end else begin
              r_state <= S_READ_WAIT;
            end
          end
        end
        S_WRITE: begin
          if (r_s_we) begin
            r_write_count <= 16'(r_write_count + 16'd1);
            r_state       <= S_IDLE;
          end else if (r_s_en) begin
            r_state <= S_IDLE;
          end else begin
            r_wr_addr <= r_s_addr[DEPTH_W-1:0];
            r_wr_data <= r_s_data;
          end
        end
        S_READ_WAIT: begin
          if (!w_rd_ok) begin
            r_state <= S_IDLE;
          end else if (w_addr_chg) begin
            r_rd_addr <= r_s_addr;
            r_cnt     <= 4'd1;
            if (LAT <= 4'd1) begin
              r_state <= S_READ_DRIVE;
              r_drive <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc >= LAT) begin
              r_state <= S_READ_DRIVE;
              r_drive <= 1'b1;
            end
          end
        end
        S_READ_DRIVE: begin
          if (!w_rd_ok) begin
            r_state <= S_IDLE;
            r_drive <= 1'b0;
          end else if (w_addr_chg) begin
            r_state   <= S_READ_WAIT;
            r_drive   <= 1'b0;
            r_rd_addr <= r_s_addr;
            r_cnt     <= 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_drive <= 1'b0;
        end
      endcase
    end
  end

  // Drive only persists while s_addr == rd_addr, so s_addr is the read index.
  sram_resp_array #(
    .DEPTH_W (DEPTH_W),
    .DATA_W  (DATA_W)
  ) u_array (
    .i_clk   (CLK),
    .i_we    (w_commit),
    .i_waddr (r_wr_addr),
    .i_wdata (r_wr_data),
    .i_raddr (r_s_addr[DEPTH_W-1:0]),
    .o_rdata (w_rdata)
  );

  assign data        = r_drive ? w_rdata : {DATA_W{1'bz}};
  assign conflict    = r_conflict;
  assign write_count = r_write_count;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: vector table, corner sequences
// and randomized write/read traffic against a word-array model.
module tb_sram_responder;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic        OE;
  logic        WE;
  logic [17:0] address;
  wire  [15:0] data;
  logic        conflict;
  logic [15:0] write_count;
  logic [15:0] tb_d;
  logic        tb_dv;

  assign data = tb_dv ? tb_d : 16'bz;

  sram_responder dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .OE          (OE),
    .WE          (WE),
    .address     (address),
    .data        (data),
    .conflict    (conflict),
    .write_count (write_count)
  );

  always #5 CLK = ~CLK;

  wire w_drv = dut.r_drive;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_mem [256];
  bit          m_valid [256];
  logic [15:0] m_wc;
  bit          m_conf;

  typedef struct {
    logic        en, oe, we;
    logic [17:0] a;
    logic        dv;
    logic [15:0] d;
    logic        x_drv;
    logic [15:0] x_dat;
    logic [15:0] x_wc;
  } vec_t;

  vec_t tbl [22];

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pins(input logic en, input logic oe, input logic we,
                      input logic [17:0] a, input logic dv,
                      input logic [15:0] d);
    EN = en; OE = oe; WE = we; address = a; tb_dv = dv; tb_d = d;
  endtask

  task automatic idle(input int n);
    pins(1, 1, 1, address, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_status(input string nm);
    chk({nm, " conflict"}, {31'd0, conflict}, {31'd0, m_conf});
    chk({nm, " write_count"}, {16'd0, write_count}, {16'd0, m_wc});
  endtask

  // Data for the final WE-low cycle is what lands in the array.
  task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                          input int len);
    for (int i = 0; i < len; i++) begin
      pins(0, 1, 0, a, 1, (i == len - 1) ? d : 16'($urandom));
      tick();
      chk("write nodrive", {31'd0, w_drv}, 0);
    end
    pins(0, 1, 1, a, 1, 16'($urandom));
    tick();
    chk("write nodrive", {31'd0, w_drv}, 0);
    idle(1);
    m_mem[a[7:0]]   = d;
    m_valid[a[7:0]] = 1;
    m_wc            = m_wc + 16'd1;
    chk("write commit", {16'd0, write_count}, {16'd0, m_wc});
    idle(1);
  endtask

  task automatic do_read(input logic [17:0] a, input int hold);
    pins(0, 0, 1, a, 0, 0);
    for (int j = 1; j <= hold; j++) begin
      tick();
      chk("read drive", {31'd0, w_drv}, {31'd0, (j >= LAT + 1)});
      if (j >= LAT + 1) chk("read data", {16'd0, data}, {16'd0, m_mem[a[7:0]]});
    end
    idle(2);
    chk("read release", {31'd0, w_drv}, 0);
  endtask

  initial begin
    tbl[0]  = '{0,1,0,18'd8,1,16'h0005, 0,16'h0,16'd0};
    tbl[1]  = '{0,1,1,18'd8,1,16'h1111, 0,16'h0,16'd0};
    tbl[2]  = '{1,1,1,18'd8,0,16'h0000, 0,16'h0,16'd1};
    tbl[3]  = '{0,1,0,18'd9,1,16'hA5A5, 0,16'h0,16'd1};
    tbl[4]  = '{0,1,1,18'd9,1,16'h0000, 0,16'h0,16'd1};
    tbl[5]  = '{1,1,1,18'd9,0,16'h0000, 0,16'h0,16'd2};
    tbl[6]  = '{0,0,1,18'd8,0,16'h0000, 0,16'h0,16'd2};
    tbl[7]  = '{0,0,1,18'd8,0,16'h0000, 0,16'h0,16'd2};
    tbl[8]  = '{0,0,1,18'd8,0,16'h0000, 1,16'h0005,16'd2};
    tbl[9]  = '{0,0,1,18'd8,0,16'h0000, 1,16'h0005,16'd2};
    tbl[10] = '{1,1,1,18'd8,0,16'h0000, 1,16'h0005,16'd2};
    tbl[11] = '{1,1,1,18'd8,0,16'h0000, 0,16'h0,16'd2};
    tbl[12] = '{0,0,1,18'd8,0,16'h0000, 0,16'h0,16'd2};
    tbl[13] = '{0,0,1,18'd9,0,16'h0000, 0,16'h0,16'd2};
    tbl[14] = '{0,0,1,18'd9,0,16'h0000, 0,16'h0,16'd2};
    tbl[15] = '{0,0,1,18'd9,0,16'h0000, 1,16'hA5A5,16'd2};
    tbl[16] = '{0,0,1,18'd9,0,16'h0000, 1,16'hA5A5,16'd2};
    tbl[17] = '{0,0,1,18'd8,0,16'h0000, 1,16'hA5A5,16'd2};
    tbl[18] = '{0,0,1,18'd8,0,16'h0000, 0,16'h0,16'd2};
    tbl[19] = '{0,0,1,18'd8,0,16'h0000, 1,16'h0005,16'd2};
    tbl[20] = '{1,1,1,18'd8,0,16'h0000, 1,16'h0005,16'd2};
    tbl[21] = '{1,1,1,18'd8,0,16'h0000, 0,16'h0,16'd2};

    m_wc = 0;
    m_conf = 0;
    for (int i = 0; i < 256; i++) m_valid[i] = 0;

    // Reset with random pins
    RST = 1;
    for (int i = 0; i < 2; i++) begin
      pins(1'($urandom), 1'($urandom), 1'($urandom), 18'($urandom), 0, 0);
      tick();
    end
    chk("reset drive", {31'd0, w_drv}, 0);
    chk_status("reset");
    pins(1, 1, 1, 0, 0, 0);
    RST = 0;
    idle(2);

    // Basic write/read and latency restart
    for (int i = 0; i < 22; i++) begin
      pins(tbl[i].en, tbl[i].oe, tbl[i].we, tbl[i].a, tbl[i].dv, tbl[i].d);
      tick();
      chk($sformatf("vec%0d drive", i), {31'd0, w_drv}, {31'd0, tbl[i].x_drv});
      if (tbl[i].x_drv)
        chk($sformatf("vec%0d data", i), {16'd0, data}, {16'd0, tbl[i].x_dat});
      chk($sformatf("vec%0d wcount", i), {16'd0, write_count}, {16'd0, tbl[i].x_wc});
    end
    m_mem[8] = 16'h0005; m_valid[8] = 1;
    m_mem[9] = 16'hA5A5; m_valid[9] = 1;
    m_wc = 2;
    idle(1);

    // Aborted write leaves mem[3] and the count untouched
    do_write(18'd3, 16'h3333, 1);
    pins(0, 1, 0, 18'd3, 1, 16'hBEEF);
    tick();
    pins(1, 1, 0, 18'd3, 1, 16'hBEEF);
    tick();
    tick();
    pins(1, 1, 1, 18'd3, 0, 0);
    idle(2);
    chk_status("abort");
    do_read(18'd3, 4);

    // Upper address bits alias onto the low DEPTH_W bits
    do_write(18'h00103, 16'h7777, 2);
    m_mem[3] = 16'h7777;
    do_read(18'd3, 4);

    // Read starting right after the commit sees the new data
    pins(0, 1, 0, 18'h20, 1, 16'h1234);
    tick();
    pins(0, 1, 1, 18'h20, 1, 16'h0);
    tick();
    pins(0, 0, 1, 18'h20, 0, 16'h0);
    m_mem[8'h20] = 16'h1234; m_valid[8'h20] = 1;
    m_wc = m_wc + 16'd1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk("w2r drive", {31'd0, w_drv}, {31'd0, (j >= LAT + 1)});
      if (j >= LAT + 1) chk("w2r data", {16'd0, data}, 32'h1234);
    end
    idle(2);
    chk_status("w2r");

    // Conflict: write proceeds, bus never driven, flag sticks
    pins(0, 0, 0, 18'd4, 1, 16'd7);
    tick();
    chk("conf nodrive", {31'd0, w_drv}, 0);
    pins(0, 1, 1, 18'd4, 1, 16'd0);
    tick();
    chk("conf nodrive", {31'd0, w_drv}, 0);
    pins(1, 1, 1, 18'd4, 0, 16'd0);
    tick();
    chk("conf nodrive", {31'd0, w_drv}, 0);
    m_conf = 1;
    m_mem[4] = 16'd7; m_valid[4] = 1;
    m_wc = m_wc + 16'd1;
    idle(3);
    chk_status("conflict");
    do_read(18'd4, 4);
    chk_status("conflict sticky");

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      logic [17:0] a;
      a = {10'($urandom), 8'($urandom_range(0, 15))};
      if ($urandom_range(0, 1) == 0 || !m_valid[a[7:0]])
        do_write(a, 16'($urandom), $urandom_range(1, 3));
      else
        do_read(a, LAT + 1 + $urandom_range(0, 3));
    end
    chk_status("random");

    // Reset during WRITE discards the pending write
    do_write(18'd5, 16'h5555, 1);
    pins(0, 1, 0, 18'd5, 1, 16'h9999);
    tick();
    tick();
    RST = 1;
    tick();
    RST = 0;
    m_wc = 0;
    m_conf = 0;
    idle(3);
    chk_status("rst write");
    do_read(18'd5, 4);

    // Reset during READ_DRIVE drops the bus at that edge
    pins(0, 0, 1, 18'd5, 0, 0);
    for (int j = 0; j < LAT + 2; j++) tick();
    chk("rst read pre", {31'd0, w_drv}, 1);
    RST = 1;
    tick();
    chk("rst read drive", {31'd0, w_drv}, 0);
    RST = 0;
    idle(2);
    chk("rst read idle", {31'd0, w_drv}, 0);

    // write_count wraps
    force dut.r_write_count = 16'hFFFF;
    #1;
    release dut.r_write_count;
    m_wc = 16'hFFFF;
    chk_status("wrap pre");
    do_write(18'd6, 16'h0666, 1);
    chk("wrap zero", {16'd0, write_count}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
